// File: rtl/rr_port_arbiter_pkg.sv
// Shared types for the round-robin port arbiter: FSM section encoding and
// requester source identifiers.
package rr_port_arbiter_types;

  typedef enum logic {
    POLL = 1'b0,
    SEND = 1'b1
  } rr_port_arbiter_SECTIONS;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rr_port_arbiter.sv
// Two-requester round-robin arbiter with one-item output buffer and notify/sync handshakes.
// Define RR_ARB_STATS_EN to add per-source accepted-transfer counters cnt_a/cnt_b.
module rr_port_arbiter
  import rr_port_arbiter_types::*;
#(
  parameter int POLL_HOLD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_in,
  input  logic        a_in_sync,
  output logic        a_in_notify,
  input  logic [31:0] b_in,
  input  logic        b_in_sync,
  output logic        b_in_notify,
  output logic [31:0] m_out,
  input  logic        m_out_sync,
  output logic        m_out_notify,
  output logic        m_out_src
`ifdef RR_ARB_STATS_EN
  ,
  output logic [15:0] cnt_a,
  output logic [15:0] cnt_b
`endif
);

  localparam logic [3:0] HOLD_LAST = 4'(POLL_HOLD - 1);

  rr_port_arbiter_SECTIONS section_q;
  logic        ptr_q;
  logic [3:0]  hold_q;
  logic        a_notify_q;
  logic        b_notify_q;
  logic        m_notify_q;
  logic [31:0] m_out_q;
  logic        m_src_q;

  logic        sel_sync;
  logic [31:0] sel_data;

  // In POLL the notify of the requester under ptr is always the one raised,
  // so the selected sync alone identifies a transfer.
  assign sel_sync = (ptr_q == SRC_B) ? b_in_sync : a_in_sync;
  assign sel_data = (ptr_q == SRC_B) ? b_in      : a_in;

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      section_q  <= POLL;
      ptr_q      <= SRC_A;
      hold_q     <= '0;
      a_notify_q <= 1'b1;
      b_notify_q <= 1'b0;
      m_notify_q <= 1'b0;
      m_out_q    <= '0;
      m_src_q    <= SRC_A;
    end else begin
      case (section_q)
        POLL: begin
          if (sel_sync) begin
            m_out_q    <= sel_data;
            m_src_q    <= ptr_q;
            a_notify_q <= 1'b0;
            b_notify_q <= 1'b0;
            m_notify_q <= 1'b1;
            ptr_q      <= ~ptr_q;
            hold_q     <= '0;
            section_q  <= SEND;
          end else if (hold_q == HOLD_LAST) begin
            // Hand the poll to the other requester.
            a_notify_q <= (ptr_q == SRC_B);
            b_notify_q <= (ptr_q == SRC_A);
            ptr_q      <= ~ptr_q;
            hold_q     <= '0;
          end else begin
            hold_q <= hold_q + 4'd1;
          end
        end
        SEND: begin
          if (m_out_sync) begin
            m_notify_q <= 1'b0;
            a_notify_q <= (ptr_q == SRC_A);
            b_notify_q <= (ptr_q == SRC_B);
            section_q  <= POLL;
          end
        end
      endcase
    end
  end

  assign a_in_notify  = a_notify_q;
  assign b_in_notify  = b_notify_q;
  assign m_out_notify = m_notify_q;
  assign m_out        = m_out_q;
  assign m_out_src    = m_src_q;

`ifdef RR_ARB_STATS_EN
  logic        a_xfer;
  logic        b_xfer;
  logic [15:0] cnt_a_q;
  logic [15:0] cnt_b_q;

  assign a_xfer = a_notify_q && a_in_sync;
  assign b_xfer = b_notify_q && b_in_sync;

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (a_xfer) cnt_a_q <= cnt_a_q + 16'd1;
      if (b_xfer) cnt_b_q <= cnt_b_q + 16'd1;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Self-checking bench for rr_port_arbiter: two instances (POLL_HOLD=1 and 3)
// share stimulus and are compared every cycle against a turn/wait/item model.
module tb_rr_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_in, b_in;
  logic        a_sync, b_sync, m_sync;

  logic        a_ntf [2];
  logic        b_ntf [2];
  logic        m_ntf [2];
  logic        m_src [2];
  logic [31:0] m_out [2];
`ifdef RR_ARB_STATS_EN
  logic [15:0] cnt_a [2];
  logic [15:0] cnt_b [2];
`endif

  rr_port_arbiter #(.POLL_HOLD(1)) dut (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_in_sync(a_sync), .a_in_notify(a_ntf[0]),
    .b_in(b_in), .b_in_sync(b_sync), .b_in_notify(b_ntf[0]),
    .m_out(m_out[0]), .m_out_sync(m_sync), .m_out_notify(m_ntf[0]),
    .m_out_src(m_src[0])
`ifdef RR_ARB_STATS_EN
    , .cnt_a(cnt_a[0]), .cnt_b(cnt_b[0])
`endif
  );

  rr_port_arbiter #(.POLL_HOLD(3)) dut3 (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_in_sync(a_sync), .a_in_notify(a_ntf[1]),
    .b_in(b_in), .b_in_sync(b_sync), .b_in_notify(b_ntf[1]),
    .m_out(m_out[1]), .m_out_sync(m_sync), .m_out_notify(m_ntf[1]),
    .m_out_src(m_src[1])
`ifdef RR_ARB_STATS_EN
    , .cnt_a(cnt_a[1]), .cnt_b(cnt_b[1])
`endif
  );

  int checks = 0;
  int errors = 0;
  bit checks_on = 0;

  // Model: per instance, whether an item is waiting for the consumer, whose
  // turn it is to be offered service, how long that turn has lasted.
  int          hold_cfg [2] = '{1, 3};
  bit          sending  [2];
  int          turn     [2];
  int          waited   [2];
  logic [31:0] item     [2];
  int          src      [2];
  int          accepted [2][2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        sending[k] = 0; turn[k] = 0; waited[k] = 0; item[k] = 0; src[k] = 0;
        accepted[k][0] = 0; accepted[k][1] = 0;
      end else if (!sending[k]) begin
        if ((turn[k] == 0) ? a_sync : b_sync) begin
          item[k] = (turn[k] == 0) ? a_in : b_in;
          src[k]  = turn[k];
          accepted[k][turn[k]]++;
          sending[k] = 1;
          turn[k]    = 1 - turn[k];
          waited[k]  = 0;
        end else if (waited[k] + 1 >= hold_cfg[k]) begin
          turn[k]   = 1 - turn[k];
          waited[k] = 0;
        end else begin
          waited[k]++;
        end
      end else if (m_sync) begin
        sending[k] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("a_notify[%0d]", k), 32'(a_ntf[k]), 32'(!sending[k] && turn[k] == 0));
      check($sformatf("b_notify[%0d]", k), 32'(b_ntf[k]), 32'(!sending[k] && turn[k] == 1));
      check($sformatf("m_notify[%0d]", k), 32'(m_ntf[k]), 32'(sending[k]));
      check($sformatf("m_out[%0d]", k), m_out[k], item[k]);
      check($sformatf("m_src[%0d]", k), 32'(m_src[k]), 32'(src[k]));
      check($sformatf("exclusive[%0d]", k),
            32'(int'(a_ntf[k]) + int'(b_ntf[k]) + int'(m_ntf[k]) <= 1), 32'd1);
`ifdef RR_ARB_STATS_EN
      check($sformatf("cnt_a[%0d]", k), 32'(cnt_a[k]), 32'(accepted[k][0] & 16'hFFFF));
      check($sformatf("cnt_b[%0d]", k), 32'(cnt_b[k]), 32'(accepted[k][1] & 16'hFFFF));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (checks_on) compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; a_in = '0; b_in = '0; a_sync = 0; b_sync = 0; m_sync = 0;
    step();
    checks_on = 1;

    // Release with A offering 7: notify now, data out next cycle.
    a_in = 32'd7; a_sync = 1;
    do_reset();
    check("rel_a_notify", 32'(a_ntf[0]), 32'd1);
    step();
    check("rel_m_out", m_out[0], 32'd7);
    check("rel_m_src", 32'(m_src[0]), 32'd0);
    check("rel_m_notify", 32'(m_ntf[0]), 32'd1);

    // Both requesters busy, consumer always ready: 1,2,1,2 every 2 cycles.
    do_reset();
    a_in = 32'd1; b_in = 32'd2; a_sync = 1; b_sync = 1; m_sync = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i % 2 == 0) begin
        check("alt_m_notify", 32'(m_ntf[0]), 32'd1);
        check("alt_m_out", m_out[0], ((i / 2) % 2 == 0) ? 32'd1 : 32'd2);
      end else begin
        check("alt_gap", 32'(m_ntf[0]), 32'd0);
      end
    end

    // Idle polling: hold 1 alternates each cycle, hold 3 every three.
    a_sync = 0; b_sync = 0; m_sync = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      check("idle_h1_a", 32'(a_ntf[0]), 32'(i % 2 == 0));
      check("idle_h3_a", 32'(a_ntf[1]), 32'((i / 3) % 2 == 0));
      check("idle_h3_b", 32'(b_ntf[1]), 32'((i / 3) % 2 == 1));
      step();
    end

    // Consumer stalls five cycles while inputs toggle.
    do_reset();
    a_in = 32'd55; a_sync = 1;
    step();
    for (int i = 0; i < 5; i++) begin
      a_sync = i[0]; b_sync = ~i[0]; a_in = 32'(100 + i); b_in = 32'(200 + i);
      step();
      check("stall_m_out", m_out[0], 32'd55);
      check("stall_a_ntf", 32'(a_ntf[0]), 32'd0);
      check("stall_b_ntf", 32'(b_ntf[0]), 32'd0);
    end
    a_sync = 0; b_sync = 0; m_sync = 1;
    step();
    check("stall_done_m", 32'(m_ntf[0]), 32'd0);
    check("stall_done_b", 32'(b_ntf[0]), 32'd1);
    m_sync = 0;

    // Reset wins over a simultaneous consumer accept.
    b_in = 32'd9; b_sync = 1;
    step();
    check("rs_captured", m_out[0], 32'd9);
    b_sync = 0; m_sync = 1; rst = 1;
    step();
    rst = 0; m_sync = 0;
    check("rs_m_notify", 32'(m_ntf[0]), 32'd0);
    check("rs_a_notify", 32'(a_ntf[0]), 32'd1);
    check("rs_m_out", m_out[0], 32'd0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      a_sync = 1'($urandom_range(0, 1));
      b_sync = 1'($urandom_range(0, 1));
      m_sync = ($urandom_range(0, 9) < 7);
      a_in   = $urandom;
      b_in   = $urandom;
      rst    = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
